serial_frame_tx: RTL
====================

// Module: serial_frame_tx
// PURPOSE
//   Transmit end of the single-bit serial link that the my_fsm sequence detector receives.
//   - Takes a parallel word with a start strobe.
//   - Emits a framed bitstream on one wire: preamble, data MSB first, optional parity, idle gap.
//   - Drives the detector's `in` input directly; one bit per clock.
// PARAMETERS
//   DATA_W    8        payload width in bits
//   PRE_W     4        preamble length in bits
//   PREAMBLE  4'b1011  preamble pattern, sent MSB first (width PRE_W)
//   GAP_CYC   2        idle (out=0) cycles appended after each frame, >=1
// PORTS
//   clock  in   1       rising-edge clock
//   reset  in   1       synchronous, active-high reset
//   start  in   1       request a frame; sampled only in IDLE
//   data   in   DATA_W  payload; latched on the accepting edge
//   out    out  1       serial bitstream, registered
//   busy   out  1       high from the first preamble bit through the last gap cycle
//   done   out  1       one-cycle pulse on the first IDLE cycle after a completed frame
// BEHAVIOUR
//   Reset (reset=1 at a rising edge):
//   - state=IDLE; out=0, busy=0, done=0; bit counter and shift register cleared.
//   - Applies mid-frame: the frame is aborted, out=0 from the next edge, no done pulse.
//   FSM states: IDLE -> PRE -> DATA -> [PAR] -> GAP -> IDLE.
//   - IDLE: out=0, busy=0. On an edge with start=1: latch data, go to PRE.
//     The first preamble bit appears on out at that same edge (latency 1 cycle from start sample).
//   - PRE: PRE_W cycles, out=PREAMBLE[PRE_W-1-i]. After the last bit go to DATA.
//   - DATA: DATA_W cycles, out=data_q[DATA_W-1-i] (MSB first). Then PAR if enabled, else GAP.
//   - PAR: 1 cycle (present only with PARITY_EN).
//   - GAP: GAP_CYC cycles, out=0, busy=1. Then IDLE with done=1 for exactly that first IDLE cycle.
//   Boundaries:
//   - start while busy=1: ignored; no queueing. data changes while busy: ignored (latched copy used).
//   - start=1 in the done cycle: accepted; the next frame begins on the following edge.
//     start held high gives back-to-back frames with exactly one IDLE (done) cycle between them.
//   - Bit counter width is clog2(max(PRE_W, DATA_W, GAP_CYC)) and resets to 0 on every state change.
//   - Frame length in busy cycles: PRE_W + DATA_W + GAP_CYC (+1 with PARITY_EN).
// CONFIGURATION
//   SERIAL_FRAME_TX_PARITY_EN
//   - Defined: PAR state is inserted after DATA; out = ^data_q (even parity); busy lasts one cycle longer.
//   - Undefined: no PAR state; DATA goes directly to GAP; no parity logic is synthesised.
// TESTING (defaults: PREAMBLE=1011, DATA_W=8, GAP_CYC=2; cycle 0 = edge sampling start)
//   1. reset=1 for 2 edges with start=1 -> out=0, busy=0, done=0 throughout; no frame after release until start is sampled.
//   2. start=1 at cycle 0, data=8'hA5 -> out on cycles 1..12 = 1,0,1,1,1,0,1,0,0,1,0,1;
//      cycles 13..14 = 0; busy=1 on cycles 1..14; done=1 on cycle 15 only.
//   3. During test 2, pulse start with data=8'hFF at cycle 6 -> stream identical to test 2; no second frame.
//   4. reset=1 at cycle 9 (during the 5th data bit) -> out=0, busy=0 from cycle 10; done never asserts.
//   5. start held at 1 with data=8'h3C -> frames repeat; done cycle at 15, next preamble '1' at cycle 16.
//   6. PARITY_EN defined -> data=8'hA5 gives parity bit 0 at cycle 13; data=8'h01 gives parity bit 1;
//      done moves to cycle 16.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: frames a parallel word as preamble, MSB-first data, optional parity and idle gap on one wire
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN adds one even-parity bit after the data.
module serial_frame_tx #(
  parameter int DATA_W = 8,
  parameter int PRE_W = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = 4'b1011,
  parameter int GAP_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              out,
  output logic              busy,
  output logic              done
);
  localparam int F_W = PRE_W + DATA_W;
  localparam int PD_MAX = PRE_W > DATA_W ? PRE_W : DATA_W;
  localparam int MAX_L = PD_MAX > GAP_CYC ? PD_MAX : GAP_CYC;
  localparam int CNT_W = MAX_L > 1 ? $clog2(MAX_L) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAR, S_GAP} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [F_W-1:0]   r_sh;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             r_par;
`endif
  // Frame sequencer: preamble and payload share one shift register, the first preamble bit leaves on the accepting edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= S_PRE;
            r_cnt   <= '0;
            r_sh    <= {PREAMBLE, data} << 1;
            out     <= PREAMBLE[PRE_W-1];
            busy    <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_par   <= ^data;
`endif
          end
        end
        S_PRE: begin
          out     <= r_sh[F_W-1];
          r_sh    <= r_sh << 1;
          r_cnt   <= (r_cnt == PRE_LAST) ? '0 : r_cnt + 1'b1;
          r_state <= (r_cnt == PRE_LAST) ? S_DATA : S_PRE;
        end
        S_DATA: begin
          r_cnt <= (r_cnt == DATA_LAST) ? '0 : r_cnt + 1'b1;
          r_sh  <= r_sh << 1;
          if (r_cnt == DATA_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_state <= S_PAR;
            out     <= r_par;
`else
            r_state <= S_GAP;
            out     <= 1'b0;
`endif
          end else begin
            out <= r_sh[F_W-1];
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PAR: begin
          r_state <= S_GAP;
          r_cnt   <= '0;
          out     <= 1'b0;
        end
`endif
        S_GAP: begin
          out     <= 1'b0;
          r_cnt   <= (r_cnt == GAP_LAST) ? '0 : r_cnt + 1'b1;
          r_state <= (r_cnt == GAP_LAST) ? S_IDLE : S_GAP;
          busy    <= (r_cnt != GAP_LAST);
          done    <= (r_cnt == GAP_LAST);
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          out     <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule
